// File: rtl/uart_rx_ctrl_gen.sv
// Purpose : oversampled UART receiver with majority-vote bit decisions, parity/stop checking and optional break detection.
// Latency : result pulse (DATA_VALID / PAR_ERR / STP_ERR / BREAK) is registered one cycle after the last stop bit's decision cycle.
// Backpr. : none; the serial line cannot be stalled, so each result is a single-cycle pulse that must be captured when seen.
//
// Ports   : CLK, RST (async, active-low); RX_IN serial line (idle high);
//           PAR_EN / PAR_TYP / STOP2 / prescale frame format, latched at the start edge;
//           P_DATA received word; DATA_VALID, PAR_ERR, STP_ERR, BREAK one-cycle pulses; BUSY high outside IDLE.
// Config  : define UART_RX_BREAK_DET_EN to report all-zero frames as BREAK (otherwise BREAK is tied low).
module uart_rx_ctrl_gen #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               STOP2,
  input  logic [PRESC_W-1:0] prescale,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               DATA_VALID,
  output logic               PAR_ERR,
  output logic               STP_ERR,
  output logic               BREAK,
  output logic               BUSY
);

  localparam int BCW = $clog2(DATA_W);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP_A, STOP_B} state_t;

  state_t             state, state_nxt;
  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] p_lat;
  logic [PRESC_W-1:0] half;
  logic [BCW-1:0]     bit_cnt;
  logic [DATA_W-1:0]  shreg;
  logic [2:0]         smp;
  logic               par_en_l, par_typ_l, stop2_l;
  logic               par_bad, stp_bad;
  logic               bit_end, maj, stp_now, frame_end;
  logic               brk_hit, brk_wait;

  // Only the three supported oversampling ratios are honoured; anything else runs at 8.
  function automatic logic [PRESC_W-1:0] legal_p(input logic [PRESC_W-1:0] p);
    if (p == PRESC_W'(16) || p == PRESC_W'(32)) return p;
    return PRESC_W'(8);
  endfunction

  assign half    = p_lat >> 1;
  assign bit_end = (edge_cnt == p_lat - PRESC_W'(1));
  // The three mid-bit samples are all stored before the decision cycle (P >= 8).
  assign maj     = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign stp_now = stp_bad | ~maj;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      IDLE:   if (!RX_IN && !brk_wait) state_nxt = START;
      START:  if (bit_end) state_nxt = maj ? IDLE : DATA;
      DATA:   if (bit_end && bit_cnt == BIT_LAST) state_nxt = par_en_l ? PARITY : STOP_A;
      PARITY: if (bit_end) state_nxt = STOP_A;
      STOP_A: if (bit_end) begin
                if (stop2_l && !brk_hit) state_nxt = STOP_B;
                else begin
                  state_nxt = IDLE;
                  frame_end = 1'b1;
                end
              end
      STOP_B: if (bit_end) begin
                state_nxt = IDLE;
                frame_end = 1'b1;
              end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      p_lat      <= PRESC_W'(8);
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      stop2_l    <= 1'b0;
      shreg      <= '0;
      smp        <= 3'b111;
      par_bad    <= 1'b0;
      stp_bad    <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      BREAK      <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      BREAK      <= brk_hit;
      BUSY       <= (state_nxt != IDLE);

      if (state == IDLE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
        if (state_nxt == START) begin
          p_lat     <= legal_p(prescale);
          par_en_l  <= PAR_EN;
          par_typ_l <= PAR_TYP;
          stop2_l   <= STOP2;
          par_bad   <= 1'b0;
          stp_bad   <= 1'b0;
        end
      end else begin
        edge_cnt <= bit_end ? '0 : edge_cnt + PRESC_W'(1);
        if (edge_cnt == half - PRESC_W'(1)) smp[0] <= RX_IN;
        if (edge_cnt == half)               smp[1] <= RX_IN;
        if (edge_cnt == half + PRESC_W'(1)) smp[2] <= RX_IN;
        if (bit_end) begin
          case (state)
            DATA: begin
              shreg   <= {maj, shreg[DATA_W-1:1]};
              bit_cnt <= bit_cnt + BCW'(1);
            end
            PARITY:         if (((^shreg) ^ maj) != par_typ_l) par_bad <= 1'b1;
            STOP_A, STOP_B: if (!maj) stp_bad <= 1'b1;
            default: ;
          endcase
        end
        // A bad frame leaves P_DATA holding the last good word.
        if (frame_end && !brk_hit) begin
          if (!par_bad && !stp_now) begin
            P_DATA     <= shreg;
            DATA_VALID <= 1'b1;
          end else begin
            PAR_ERR <= par_bad;
            STP_ERR <= stp_now;
          end
        end
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic all_zero;

  assign brk_hit = (state == STOP_A) && bit_end && !maj && all_zero;

  // After a break the line is held low; wait for it to return high before hunting a new start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      all_zero <= 1'b0;
      brk_wait <= 1'b0;
    end else begin
      if (state == IDLE) all_zero <= 1'b1;
      else if (bit_end && maj && (state == DATA || state == PARITY)) all_zero <= 1'b0;
      if (brk_hit) brk_wait <= 1'b1;
      else if (state == IDLE && RX_IN) brk_wait <= 1'b0;
    end
  end
`else
  assign brk_hit  = 1'b0;
  assign brk_wait = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl_gen.sv
// Purpose : randomized and directed frames against a frame-level reference model of the UART receiver.
// Latency : results are collected by a monitor and compared in order at the end of the run.
// Backpr. : none; the bench drives the serial line cycle by cycle.
module tb_uart_rx_ctrl_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR, BREAK, BUSY;

  uart_rx_ctrl_gen #(.DATA_W(8), .PRESC_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STOP2(STOP2), .prescale(prescale), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR), .BREAK(BREAK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // kind = {BUSY, BREAK, STP_ERR, PAR_ERR, DATA_VALID}; data = P_DATA seen with the pulse
  typedef struct {
    logic [4:0] kind;
    logic [7:0] data;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         long_pulses = 0;
  logic [3:0] prev_p = '0;
  logic [7:0] last_good = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    ev_t e;
    if ({BREAK, STP_ERR, PAR_ERR, DATA_VALID} & prev_p) long_pulses++;
    prev_p <= {BREAK, STP_ERR, PAR_ERR, DATA_VALID};
    if (DATA_VALID || PAR_ERR || STP_ERR || BREAK) begin
      e.kind = {BUSY, BREAK, STP_ERR, PAR_ERR, DATA_VALID};
      e.data = P_DATA;
      obs_q.push_back(e);
    end
  end

  // Frame-level expectation straight from the line contents.
  task automatic model(input logic [7:0] d, input bit pe, input bit typ, input bit st2,
                       input bit pb, input bit s1, input bit s2);
    ev_t e;
    bit  par_bad, stp_bad;
    par_bad = pe && (((^d) ^ pb) != typ);
    stp_bad = !s1 || (st2 && !s2);
    e.data  = last_good;
`ifdef UART_RX_BREAK_DET_EN
    if (d == 8'h00 && (!pe || !pb) && !s1) begin
      e.kind = 5'b01000;
      exp_q.push_back(e);
      return;
    end
`endif
    if (!par_bad && !stp_bad) begin
      last_good = d;
      e.data    = d;
      e.kind    = 5'b00001;
    end else begin
      e.kind = {3'b000, par_bad, 1'b0} | {2'b00, stp_bad, 2'b00};
    end
    exp_q.push_back(e);
  endtask

  // Drives one frame at its effective bit period. glitch_c flips the line for one cycle;
  // abort_c >= 0 stops driving at that cycle without expecting any result.
  task automatic send_frame(input logic [7:0] d, input int p_in, input bit pe, input bit typ,
                            input bit st2, input bit pbad, input bit s1, input bit s2,
                            input int glitch_c, input int gap, input int abort_c);
    int p, total, c;
    bit bits[$];
    bit pb, v;
    p  = (p_in == 16 || p_in == 32) ? p_in : 8;
    pb = (^d) ^ typ ^ pbad;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pb);
    bits.push_back(s1);
    if (st2) bits.push_back(s2);
    prescale = 6'(p_in);
    PAR_EN   = pe;
    PAR_TYP  = typ;
    STOP2    = st2;
    total    = bits.size() * p;
    for (c = 0; c < total && !(abort_c >= 0 && c >= abort_c); c++) begin
      if (c == 2) begin
        // Format inputs are only looked at on the start edge.
        prescale = 6'($urandom);
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        STOP2    = 1'($urandom);
      end
      v = bits[c / p];
      if (c == glitch_c) v = !v;
      RX_IN = v;
      @(negedge CLK);
    end
    RX_IN = 1'b1;
    if (abort_c < 0) model(d, pe, typ, st2, pb, s1, s2);
    repeat (gap) @(negedge CLK);
  endtask

  initial begin
    int p, n;
    int plist[9] = '{8, 16, 32, 8, 16, 32, 12, 0, 63};

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_p_data", P_DATA, 0);
    chk("rst_dv", DATA_VALID, 0);
    chk("rst_par_err", PAR_ERR, 0);
    chk("rst_stp_err", STP_ERR, 0);
    chk("rst_break", BREAK, 0);
    chk("rst_busy", BUSY, 0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_busy", BUSY, 0);

    // 0xA5, P=8, no parity, one stop
    send_frame(8'hA5, 8, 0, 0, 0, 0, 1, 1, -1, 3, -1);
    // 0x3C, P=16, odd parity, wrong parity bit
    send_frame(8'h3C, 16, 1, 1, 0, 1, 1, 1, -1, 3, -1);

    // Start glitch: 10 low cycles at P=32
    prescale = 6'd32;
    RX_IN = 1'b0;
    repeat (5) @(negedge CLK);
    chk("glitch_busy_hi", BUSY, 1);
    repeat (5) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (23) @(negedge CLK);
    chk("glitch_busy_lo", BUSY, 0);

    // Two stop bits, second one low
    send_frame(8'h55, 8, 0, 0, 1, 0, 1, 0, -1, 3, -1);
    // Single-cycle glitch at mid-sample of data bit 3 (frame bit 4)
    send_frame(8'hFF, 16, 0, 0, 0, 0, 1, 1, 1 + 4 * 16 + 8, 3, -1);
    // Back-to-back frames, one idle cycle between
    send_frame(8'h12, 8, 1, 0, 0, 0, 1, 1, -1, 1, -1);
    send_frame(8'hE7, 8, 1, 1, 1, 0, 1, 1, -1, 1, -1);
    send_frame(8'h6B, 8, 0, 0, 0, 0, 1, 1, -1, 3, -1);

    // Reset in the middle of data bit 4, then a clean 0x81
    send_frame(8'hC3, 8, 0, 0, 0, 0, 1, 1, -1, 0, 5 * 8 + 4);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_busy", BUSY, 0);
    chk("async_rst_p_data", P_DATA, 0);
    last_good = 8'h00;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_busy", BUSY, 0);
    send_frame(8'h81, 8, 0, 0, 0, 0, 1, 1, -1, 3, -1);

    // All-zero frame: break or stop error depending on build
    send_frame(8'h00, 8, 0, 0, 0, 0, 0, 0, -1, 4, -1);
    send_frame(8'h5A, 16, 0, 0, 0, 0, 1, 1, -1, 3, -1);

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      p = plist[$urandom_range(0, 8)];
      n = (p == 16 || p == 32) ? p : 8;
      send_frame(8'($urandom), p, 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 1) == 0) ? $urandom_range(2, 10 * n) : -1,
                 $urandom_range(1, 4), -1);
    end

    repeat (20) @(negedge CLK);
    chk("event_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("ev%0d_kind", i), obs_q[i].kind, exp_q[i].kind);
      chk($sformatf("ev%0d_data", i), obs_q[i].data, exp_q[i].data);
    end
    chk("single_cycle_pulses", long_pulses, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
